// File: rtl/bram_portb_arbiter.sv
// Arbitrates BRAM port B between N_REQ requesters with optional CPU priority and RMW lock.
// Each access runs IDLE -> ACCESS -> RESP; BRAM-side outputs are registered.
module bram_portb_arbiter #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int PRIO0  = 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ-1:0]          i_we,
   input  logic [N_REQ-1:0]          i_lock,
   input  logic [N_REQ*ADDR_W-1:0]   i_addr,
   input  logic [N_REQ*DATA_W-1:0]   i_wdata,
   output logic [N_REQ-1:0]          o_ack,
   output logic [DATA_W-1:0]         o_rdata,
   output logic [N_REQ-1:0]          o_grant,
   output logic                      o_busy,
   output logic                      o_bram_web,
   output logic [ADDR_W-1:0]         o_bram_addrb,
   output logic [DATA_W-1:0]         o_bram_dib,
   input  logic [DATA_W-1:0]         i_bram_dob
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   state_e              state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic                web_q, web_d;
   logic [ADDR_W-1:0]   addrb_q, addrb_d;
   logic [DATA_W-1:0]   dib_q, dib_d;
   logic [IDX_W-1:0]    rrPtr_q, rrPtr_d;
   logic                lockValid_q, lockValid_d;
   logic [IDX_W-1:0]    lockOwner_q, lockOwner_d;

   logic                found;
   logic [IDX_W-1:0]    winIdx;
   logic [IDX_W-1:0]    candIdx;
   int                  cand;

   // A live lock owner wins outright; otherwise priority/round-robin search after rrPtr.
   always_comb begin
      found   = 1'b0;
      winIdx  = '0;
      candIdx = '0;
      cand    = 0;
      if (lockValid_q && i_req[lockOwner_q]) begin
         found  = 1'b1;
         winIdx = lockOwner_q;
      end else if ((PRIO0 != 0) && i_req[0]) begin
         found  = 1'b1;
         winIdx = '0;
      end else begin
         for (int s = 1; s <= N_REQ; s++) begin
            cand = int'(rrPtr_q) + s;
            if (cand >= N_REQ) begin
               cand = cand - N_REQ;
            end
            candIdx = IDX_W'(cand);
            if (!found && i_req[candIdx] && !((PRIO0 != 0) && (cand == 0))) begin
               found  = 1'b1;
               winIdx = candIdx;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ack_d       = ack_q;
      web_d       = web_q;
      addrb_d     = addrb_q;
      dib_d       = dib_q;
      rrPtr_d     = rrPtr_q;
      lockValid_d = lockValid_q;
      lockOwner_d = lockOwner_q;
      case (state_q)
         IDLE: begin
            if (lockValid_q && !i_req[lockOwner_q]) begin
               lockValid_d = 1'b0;
            end
            if (found) begin
               addrb_d = i_addr[int'(winIdx)*ADDR_W +: ADDR_W];
               dib_d   = i_wdata[int'(winIdx)*DATA_W +: DATA_W];
               web_d   = i_we[winIdx];
               grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << winIdx;
               // The CPU winning on priority must not disturb round-robin fairness among the rest.
               if (!((PRIO0 != 0) && (winIdx == '0))) begin
                  rrPtr_d = winIdx;
               end
               lockValid_d = i_lock[winIdx];
               lockOwner_d = winIdx;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            web_d   = 1'b0;
            ack_d   = grant_q;
            state_d = RESP;
         end
         RESP: begin
            ack_d   = '0;
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ack_q       <= '0;
         web_q       <= 1'b0;
         addrb_q     <= '0;
         dib_q       <= '0;
         rrPtr_q     <= IDX_W'(N_REQ - 1);
         lockValid_q <= 1'b0;
         lockOwner_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         web_q       <= web_d;
         addrb_q     <= addrb_d;
         dib_q       <= dib_d;
         rrPtr_q     <= rrPtr_d;
         lockValid_q <= lockValid_d;
         lockOwner_q <= lockOwner_d;
      end
   end

   assign o_ack        = ack_q;
   assign o_grant      = grant_q;
   assign o_busy       = (state_q != IDLE);
   assign o_bram_web   = web_q;
   assign o_bram_addrb = addrb_q;
   assign o_bram_dib   = dib_q;
   assign o_rdata      = i_bram_dob;

endmodule
